// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one iterative multiplier core between
// NREQ requesters: grant, issue start, wait for done (or watchdog), respond.
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int BW      = 16,
  parameter int PW      = 16,
  parameter int TIMEOUT = 63
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_a,
  input  logic [NREQ*BW-1:0]       req_b,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [PW-1:0]            rsp_p,
  output logic                     rsp_err,
  output logic                     mul_start,
  output logic [AW-1:0]            mul_a,
  output logic [BW-1:0]            mul_b,
  input  logic                     mul_done,
  input  logic [PW-1:0]            mul_p,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_mul_a;
  logic [BW-1:0]   r_mul_b;
  logic [PW-1:0]   r_rsp_p;
  logic            r_rsp_err;
  logic [IW-1:0]   w_win;
  logic            w_any;
  logic            w_timeout;
  logic [IW-1:0]   w_rr_next;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[IW'((int'(r_rr_ptr) + k) % NREQ)]) begin
        w_win = IW'((int'(r_rr_ptr) + k) % NREQ);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_any) begin
      req_ready[w_win] = 1'b1;
    end
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign w_rr_next = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (mul_done || w_timeout) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_rsp_p   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_mul_a <= req_a[w_win*AW +: AW];
            r_mul_b <= req_b[w_win*BW +: BW];
            r_owner <= w_win;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A done seen on the final watchdog cycle still wins over the timeout.
          if (mul_done) begin
            r_rsp_p   <= mul_p;
            r_rsp_err <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_p   <= '0;
            r_rsp_err <= 1'b1;
          end
        end
        S_RESP:  r_rr_ptr <= w_rr_next;
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = (r_state == S_RESP) && (r_owner == IW'(gi));
    end
  endgenerate

  assign mul_start = (r_state == S_ISSUE);
  assign busy      = (r_state != S_IDLE);
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_p     = r_rsp_p;
  assign rsp_err   = r_rsp_err;
  assign owner     = r_owner;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: the multiplier core is played by the
// stimulus sequence itself so done timing is exact.
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_p;
  logic        rsp_err;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [15:0] mul_b;
  logic        mul_done;
  logic [15:0] mul_p;
  logic        busy;
  logic [1:0]  owner;

  int n_vec = 0;
  int n_err = 0;

  mul_share_arbiter #(
    .NREQ(4), .AW(8), .BW(16), .PW(16), .TIMEOUT(63)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [15:0] b);
    req_a[i*8 +: 8]   = a;
    req_b[i*16 +: 16] = b;
  endtask

  // Full transaction from IDLE with the winner's request already presented.
  task automatic serve(input int w, input logic [7:0] ea, input logic [15:0] eb,
                       input logic [15:0] p, input int lat);
    #1;
    chk("ready_grant", req_ready, 32'(1 << w));
    tick();
    chk("issue_start", mul_start, 1);
    chk("issue_owner", owner, w);
    chk("issue_a", mul_a, ea);
    chk("issue_b", mul_b, eb);
    chk("issue_ready0", req_ready, 0);
    tick();
    repeat (lat - 1) tick();
    chk("wait_norsp", rsp_valid, 0);
    chk("wait_busy", busy, 1);
    mul_done = 1'b1;
    mul_p    = p;
    tick();
    chk("resp_valid", rsp_valid, 32'(1 << w));
    chk("resp_p", rsp_p, p);
    chk("resp_err", rsp_err, 0);
    mul_done = 1'b0;
    mul_p    = '0;
    tick();
    chk("idle_rsp0", rsp_valid, 0);
    chk("idle_busy0", busy, 0);
    chk("idle_owner", owner, w);
    $display("served requester %0d product 0x%0h", w, p);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    mul_done  = 1'b0;
    mul_p     = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_a", mul_a, 0);
    chk("rst_b", mul_b, 0);
    chk("rst_p", rsp_p, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_owner", owner, 0);
    reset = 1'b0;

    // Single request, done after 17 WAIT cycles, 3*5 = 15.
    set_op(0, 8'd3, 16'd5);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    chk("t1_start", mul_start, 1);
    chk("t1_a", mul_a, 3);
    chk("t1_b", mul_b, 5);
    tick();
    repeat (16) tick();
    chk("t1_norsp", rsp_valid, 0);
    mul_done = 1'b1;
    mul_p    = 16'd15;
    tick();
    chk("t1_rspv", rsp_valid, 4'b0001);
    chk("t1_rspp", rsp_p, 15);
    chk("t1_err", rsp_err, 0);
    mul_done = 1'b0;
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_rspv0", rsp_valid, 0);
    $display("t1 single request done");

    // All four requesters continuously valid from reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 16'((i + 1) * 256));
    req_valid = 4'b1111;
    serve(0, 8'd1, 16'h0100, 16'h0100, 3);
    serve(1, 8'd2, 16'h0200, 16'h0400, 5);
    serve(2, 8'd3, 16'h0300, 16'h0900, 2);
    serve(3, 8'd4, 16'h0400, 16'h1000, 4);
    serve(0, 8'd1, 16'h0100, 16'h0100, 1);

    // rr_ptr=2 after serving 1, then 4'b1011 grants 3, 0, 1.
    req_valid = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b0010;
    serve(1, 8'd2, 16'h0200, 16'h0400, 2);
    req_valid = 4'b1011;
    serve(3, 8'd4, 16'h0400, 16'h1000, 2);
    serve(0, 8'd1, 16'h0100, 16'h0100, 2);
    serve(1, 8'd2, 16'h0200, 16'h0400, 2);

    // Watchdog: core never answers.
    req_valid = 4'b0100;
    #1;
    chk("to_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    tick();
    repeat (62) tick();
    chk("to_wait63_norsp", rsp_valid, 0);
    chk("to_wait63_busy", busy, 1);
    tick();
    chk("to_rspv", rsp_valid, 4'b0100);
    chk("to_err", rsp_err, 1);
    chk("to_p", rsp_p, 0);
    tick();
    chk("to_busy0", busy, 0);
    chk("to_rspv0", rsp_valid, 0);
    $display("timeout response checked");

    // Reset during WAIT, done arriving just after reset.
    req_valid = 4'b0001;
    #1;
    chk("rw_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rw_busy", busy, 0);
    chk("rw_start", mul_start, 0);
    chk("rw_a", mul_a, 0);
    chk("rw_b", mul_b, 0);
    chk("rw_err", rsp_err, 0);
    chk("rw_rspv", rsp_valid, 0);
    reset    = 1'b0;
    mul_done = 1'b1;
    mul_p    = 16'h1234;
    tick();
    chk("rw_late_rspv", rsp_valid, 0);
    chk("rw_late_busy", busy, 0);
    chk("rw_late_start", mul_start, 0);
    mul_done = 1'b0;
    tick();
    chk("rw_after_rspv", rsp_valid, 0);
    chk("rw_after_p", rsp_p, 0);
    req_valid = 4'b1111;
    #1;
    chk("rw_rrptr0", req_ready, 4'b0001);
    req_valid = 4'b0000;
    $display("reset during wait checked");

    // Stray mul_done in IDLE and ISSUE must not complete a transaction.
    tick();
    mul_done = 1'b1;
    mul_p    = 16'hdead;
    tick();
    chk("sd_idle_busy", busy, 0);
    chk("sd_idle_rspv", rsp_valid, 0);
    req_valid = 4'b0001;
    #1;
    chk("sd_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    chk("sd_start", mul_start, 1);
    tick();
    mul_done = 1'b0;
    chk("sd_wait_busy", busy, 1);
    chk("sd_wait_rspv", rsp_valid, 0);
    tick();
    chk("sd_wait2_busy", busy, 1);
    chk("sd_wait2_rspv", rsp_valid, 0);
    tick();
    mul_done = 1'b1;
    mul_p    = 16'h0042;
    tick();
    chk("sd_rspv", rsp_valid, 4'b0001);
    chk("sd_rspp", rsp_p, 16'h0042);
    chk("sd_err", rsp_err, 0);
    mul_done = 1'b0;
    tick();
    chk("sd_idle", busy, 0);
    $display("stray done checked");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative shift-add multiplier core between NREQ requesters.
- Accepts one operand pair at a time and pulses the core's start.
- Waits for the core's done, with a watchdog timeout, then returns the product to the granted requester.
- Sits between the client blocks and the single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 8, width of operand a.
- BW, 16, width of operand b.
- PW, 16, product width.
- TIMEOUT, 63, max cycles spent in WAIT before an error response (≥ 2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  NREQ*AW  packed operand a; requester i occupies slice [i*AW +: AW].
- req_b  in  NREQ*BW  packed operand b; requester i occupies slice [i*BW +: BW].
- rsp_valid  out  NREQ  one-cycle response pulse to the owning requester.
- rsp_p  out  PW  product, valid when any rsp_valid bit is set.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- mul_start  out  1  one-cycle start pulse to the multiplier core.
- mul_a  out  AW  operand a to the core, held from ISSUE until IDLE.
- mul_b  out  BW  operand b to the core, held from ISSUE until IDLE.
- mul_done  in  1  core completion (level or pulse; first high sample in WAIT counts).
- mul_p  in  PW  core product, sampled when mul_done is seen in WAIT.
- busy  out  1  high in any state other than IDLE.
- owner  out  clog2(NREQ)  index of the current or last granted requester.

Behaviour:
- Reset, synchronous, has priority over all other activity. It sets:
  - state=IDLE, rr_ptr=0, owner=0;
  - mul_a=0, mul_b=0, rsp_p=0;
  - req_ready=0, rsp_valid=0, rsp_err=0, mul_start=0, busy=0, wait counter=0.
- Reset mid-operation abandons the transaction. No rsp_valid is issued, and the core is not re-started.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready[winner] is asserted combinationally in IDLE only; all other req_ready bits are 0.
  - On the handshake: latch req_a/req_b slices into mul_a/mul_b, set owner=winner, go to ISSUE.
  - With no valid requests, stay in IDLE with req_ready=0.
- ISSUE:
  - mul_start=1 for exactly this cycle.
  - Clear the wait counter and go to WAIT.
  - mul_done is ignored in ISSUE.
- WAIT:
  - Counter increments each cycle.
  - If mul_done=1: latch rsp_p=mul_p, rsp_err=0, go to RESP. This takes priority over timeout in the same cycle.
  - Otherwise, if counter reaches TIMEOUT-1: rsp_p=0, rsp_err=1, go to RESP.
- RESP:
  - rsp_valid[owner]=1 for this cycle only; rsp_p and rsp_err hold the latched values.
  - rr_ptr = (owner+1) mod NREQ.
  - Go to IDLE. No new grant is issued in RESP.
- Latency:
  - Handshake at cycle T, mul_start at T+1, WAIT from T+2.
  - If mul_done is first seen at cycle D ≥ T+2, rsp_valid occurs at D+1.
  - Next grant no earlier than the cycle after RESP.
- Stray input: mul_done in IDLE, ISSUE or RESP has no effect.
- Request handling:
  - req_valid dropping before grant: that requester is simply not granted. No requirement is placed on requesters holding valid.
  - Operand changes after the handshake have no effect.
- Arithmetic: the block never modifies data. rsp_p is exactly mul_p (PW bits) or 0 on timeout.
- Fairness:
  - Requesters continuously valid are each served once per NREQ grants.
  - Starvation is impossible under the timeout bound.
- owner holds its value through IDLE until the next grant.
- busy = (state != IDLE).

Test Plan:
- Reset; req_valid=4'b0001, a=8'd3, b=16'd5; core model returns 15 after 17 cycles.
  - Expect req_ready[0] in the handshake cycle and mul_start one cycle later with mul_a=3, mul_b=5.
  - Expect rsp_valid=4'b0001, rsp_p=15, rsp_err=0 exactly one cycle after mul_done.
- All four requesters valid continuously from reset. Expect grant order 0,1,2,3,0 and each rsp_valid bit pulsed once per round.
- With rr_ptr=2 (after serving 1), assert req_valid=4'b1011. Expect grant to 3, then 0, then 1.
- Core never raises mul_done, TIMEOUT=63. Expect rsp_valid[owner] in the cycle after the 63rd WAIT cycle, with rsp_err=1 and rsp_p=0; busy returns low the next cycle.
- Assert reset during WAIT with mul_done arriving the following cycle. Expect all outputs 0, no rsp_valid, and rr_ptr=0 afterwards.
- Pulse mul_done while in IDLE and ISSUE. Expect no response; the transaction still waits for a mul_done in WAIT.
